// File: rtl/inst_fetch_bridge_if.sv
// inst_fetch_bridge_if: SRAM-like instruction bus (req / addr_ok / data_ok).
interface inst_fetch_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;
  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_rdata, inst_data_ok);
  modport slave (input inst_req, inst_addr, output inst_addr_ok, inst_rdata, inst_data_ok);
endinterface

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: one bus read per PC, hands instructions to IF/ID and stalls the PC otherwise.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                flush_i,
  input  logic                id_stall_i,
  output logic                pc_stall_o,
  inst_fetch_bridge_if.master bus,
  output logic [DATA_W-1:0]   inst_o,
  output logic [ADDR_W-1:0]   inst_pc_o,
  output logic                inst_valid_o,
  output logic                adel_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_e;
  state_e            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, adel_q, adel_d;
  logic              hand;
  logic [DATA_W-1:0] hand_data;
  logic [ADDR_W-1:0] hand_pc;
  logic              hand_adel;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    req_d        = req_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    hand         = 1'b0;
    hand_data    = '0;
    hand_pc      = addr_q;
    hand_adel    = 1'b0;
    case (state_q)
      IDLE: if (!flush_i) begin
        if (pc_i[1:0] != 2'b00) begin
          hand      = !id_stall_i;
          hand_pc   = pc_i;
          hand_adel = 1'b1;
        end else begin
          addr_d  = pc_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: if (bus.inst_addr_ok) begin
        req_d        = 1'b0;
        flush_pend_d = 1'b0;
        state_d      = (flush_i || flush_pend_q) ? DISCARD : WAIT;
      end else if (flush_i) flush_pend_d = 1'b1;
      WAIT: if (flush_i) state_d = bus.inst_data_ok ? IDLE : DISCARD;
      else if (bus.inst_data_ok) begin
        hand      = !id_stall_i;
        hand_data = bus.inst_rdata;
        buf_d     = bus.inst_rdata;
        state_d   = id_stall_i ? HOLD : IDLE;
      end
      HOLD: if (flush_i) state_d = IDLE;
      else if (!id_stall_i) begin
        hand      = 1'b1;
        hand_data = buf_q;
        state_d   = IDLE;
      end
      DISCARD: state_d = bus.inst_data_ok ? IDLE : DISCARD;
      default: state_d = IDLE;
    endcase
    inst_d    = hand ? hand_data : inst_q;
    inst_pc_d = hand ? hand_pc : inst_pc_q;
    adel_d    = hand ? hand_adel : adel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      buf_q        <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      valid_q      <= 1'b0;
      adel_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      valid_q      <= hand;
      adel_q       <= adel_d;
    end
  end

  assign pc_stall_o    = !hand;
  assign bus.inst_req  = req_q;
  assign bus.inst_addr = addr_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_valid_o  = valid_q;
  assign adel_o        = adel_q;
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed scenarios plus random traffic checked against a transaction-level model.
module tb_inst_fetch_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0, id_stall_i = 1'b0;
  logic        pc_stall_o, inst_valid_o, adel_o;
  logic [31:0] inst_o, inst_pc_o;
  int          checks = 0, errors = 0;
  localparam logic [31:0] A = 32'hbfc00000;

  inst_fetch_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .id_stall_i(id_stall_i),
    .pc_stall_o(pc_stall_o), .bus(bus.master), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .adel_o(adel_o)
  );

  always #5 clk = ~clk;

  // model: a fetch in flight (busy), still awaiting address acceptance (m_req), made stale by a redirect,
  // or returned data waiting for decode (m_got)
  logic        m_busy = 0, m_req = 0, m_stale = 0, m_got = 0, m_adel = 0, m_valid = 0;
  logic [31:0] m_addr = 0, m_hold = 0, m_inst = 0, m_pc = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic [31:0] pc,
                      input logic aok, input logic dok, input logic [31:0] rd);
    logic        hand, h_adel;
    logic [31:0] h_data, h_pc;
    @(negedge clk);
    rst = r; flush_i = f; id_stall_i = s; pc_i = pc;
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
    #1;
    hand = 0; h_adel = 0; h_data = 0; h_pc = m_addr;
    if (!m_busy && !m_got) begin
      hand = !f && pc[1:0] != 0 && !s; h_adel = 1; h_pc = pc;
    end else if (m_got) begin
      hand = !f && !s; h_data = m_hold;
    end else if (!m_req) begin
      hand = dok && !m_stale && !f && !s; h_data = rd;
    end
    chk("inst_req", bus.inst_req, m_req);
    chk("inst_addr", bus.inst_addr, m_addr);
    chk("pc_stall", pc_stall_o, !hand);
    chk("valid", inst_valid_o, m_valid);
    chk("inst", inst_o, m_inst);
    chk("inst_pc", inst_pc_o, m_pc);
    chk("adel", adel_o, m_adel);
    if (r) begin
      m_busy = 0; m_req = 0; m_stale = 0; m_got = 0; m_adel = 0; m_valid = 0;
      m_addr = 0; m_hold = 0; m_inst = 0; m_pc = 0;
    end else begin
      m_valid = hand;
      if (hand) begin m_inst = h_data; m_pc = h_pc; m_adel = h_adel; end
      if (!m_busy && !m_got) begin
        if (!f && pc[1:0] == 0) begin m_busy = 1; m_req = 1; m_addr = pc; m_stale = 0; end
      end else if (m_got) begin
        if (f || !s) m_got = 0;
      end else if (m_req) begin
        if (f) m_stale = 1;
        if (aok) m_req = 0;
      end else if (dok) begin
        m_busy = 0;
        if (!m_stale && !f && s) begin m_got = 1; m_hold = rd; end
      end else if (f) m_stale = 1;
    end
  endtask

  task automatic go(input logic f, input logic s, input logic [31:0] pc, input logic aok,
                    input logic dok, input logic [31:0] rd);
    step(1'b0, f, s, pc, aok, dok, rd);
  endtask

  task automatic do_rst;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  logic        s_out, aok, dok, r, f, s;
  int          s_acc, s_dat;
  logic [31:0] s_addr, pc, rd;

  initial begin
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0;
    repeat (2) @(posedge clk);
    // best case fetch
    do_rst;
    go(0, 0, A, 0, 0, 0);
    chk("rst_req", bus.inst_req, 0); chk("rst_addr", bus.inst_addr, 0);
    chk("rst_valid", inst_valid_o, 0); chk("rst_stall", pc_stall_o, 1);
    go(0, 0, A, 1, 0, 0);
    chk("c1_req", bus.inst_req, 1); chk("c1_addr", bus.inst_addr, A);
    go(0, 0, A, 0, 1, 32'h24080001);
    chk("c2_stall", pc_stall_o, 0);
    go(0, 0, A + 4, 0, 0, 0);
    chk("c3_valid", inst_valid_o, 1); chk("c3_inst", inst_o, 32'h24080001); chk("c3_pc", inst_pc_o, A);
    // addr_ok delayed 3 cycles
    do_rst;
    go(0, 0, A + 8, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      go(0, 0, A + 8, i == 3, 0, 0);
      chk("dly_req", bus.inst_req, 1); chk("dly_addr", bus.inst_addr, A + 8); chk("dly_stall", pc_stall_o, 1);
    end
    go(0, 0, A + 8, 0, 1, 32'h11112222);
    chk("dly_hand", pc_stall_o, 0);
    // decode stall on data return
    do_rst;
    go(0, 0, A, 0, 0, 0);
    go(0, 0, A, 1, 0, 0);
    go(0, 1, A, 0, 1, 32'hcafef00d);
    chk("hold_stall0", pc_stall_o, 1);
    go(0, 1, A, 0, 0, 32'hdeadbeef);
    chk("hold_valid", inst_valid_o, 0); chk("hold_stall1", pc_stall_o, 1);
    go(0, 0, A, 0, 0, 32'h0);
    chk("hold_hand", pc_stall_o, 0);
    go(0, 0, A + 4, 0, 0, 0);
    chk("hold_out_valid", inst_valid_o, 1); chk("hold_out_inst", inst_o, 32'hcafef00d);
    // flush while request pending
    do_rst;
    go(0, 0, A, 0, 0, 0);
    go(1, 0, A, 0, 0, 0);
    go(0, 0, A + 32'h100, 1, 0, 0);
    chk("fl_req_held", bus.inst_req, 1);
    go(0, 0, A + 32'h100, 0, 1, 32'h5555aaaa);
    chk("fl_disc_stall", pc_stall_o, 1);
    go(0, 0, A + 32'h100, 0, 0, 0);
    chk("fl_no_valid", inst_valid_o, 0);
    // flush coincident with data_ok
    do_rst;
    go(0, 0, A, 0, 0, 0);
    go(0, 0, A, 1, 0, 0);
    go(1, 0, A, 0, 1, 32'h77777777);
    chk("fwd_stall", pc_stall_o, 1);
    go(0, 0, A + 32'h40, 0, 0, 0);
    chk("fwd_valid", inst_valid_o, 0); chk("fwd_idle_req", bus.inst_req, 0);
    go(0, 0, A + 32'h40, 0, 0, 0);
    chk("fwd_newreq", bus.inst_req, 1); chk("fwd_newaddr", bus.inst_addr, A + 32'h40);
    // misaligned PC
    do_rst;
    go(0, 0, A + 2, 0, 0, 0);
    chk("mis_stall", pc_stall_o, 0);
    go(0, 0, A + 4, 0, 0, 0);
    chk("mis_valid", inst_valid_o, 1); chk("mis_adel", adel_o, 1);
    chk("mis_pc", inst_pc_o, A + 2); chk("mis_inst", inst_o, 0);
    // reset while waiting for data, then a stray data_ok
    do_rst;
    go(0, 0, A, 0, 0, 0);
    go(0, 0, A, 1, 0, 0);
    step(1, 0, 0, A, 0, 0, 0);
    go(0, 0, A, 0, 1, 32'h99999999);
    chk("rw_req", bus.inst_req, 0); chk("rw_pc", inst_pc_o, 0); chk("rw_stall", pc_stall_o, 1);
    go(0, 0, A, 0, 0, 0);
    chk("rw_valid", inst_valid_o, 0); chk("rw_newreq", bus.inst_req, 1);
    // random traffic with a randomly delayed bus slave
    s_out = 0; s_acc = 0; s_dat = 0; s_addr = 0;
    for (int i = 0; i < 4000; i++) begin
      r = (i == 0) || ($urandom_range(0, 299) == 0);
      f = $urandom_range(0, 9) == 0;
      s = $urandom_range(0, 2) == 0;
      pc = $urandom & 32'hfffffffc;
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      aok = bus.inst_req && !s_out && s_acc == 0;
      dok = s_out && s_dat == 0;
      rd = dok ? (s_addr ^ 32'h5a5a0f0f) + 32'd7 : $urandom;
      step(r, f, s, pc, aok, dok, rd);
      if (r) begin
        s_out = 0; s_acc = $urandom_range(0, 3);
      end else begin
        if (aok) begin
          s_out = 1; s_addr = bus.inst_addr; s_dat = $urandom_range(0, 2); s_acc = $urandom_range(0, 3);
        end else if (bus.inst_req && s_acc > 0) s_acc--;
        if (dok) s_out = 0;
        else if (s_out && s_dat > 0) s_dat--;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Fetch-side counterpart of the program counter register: consumes the current PC, performs one instruction read per PC value over the SRAM-like instruction bus (req / addr_ok / data_ok), and hands the instruction to the IF/ID stage. It drives the PC stall that the PC register uses as the inverse of its enable. It also drops instructions made stale by a redirect (PC clear / flush) and raises an address-error flag for misaligned PCs.

## Interface
- `ADDR_W`, default 32: PC and bus address width.
- `DATA_W`, default 32: instruction width.

Ports:
- `clk` input 1: clock. All state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `pc_i` input ADDR_W: current PC from the PC register.
- `flush_i` input 1: redirect, asserted in the same cycle the PC register takes its clear/target path.
- `id_stall_i` input 1: decode stage cannot accept an instruction this cycle.
- `pc_stall_o` output 1: 1 means the PC must hold. The PC enable is its inverse.
- `inst_req` output 1: bus request, registered.
- `inst_addr` output ADDR_W: bus address, registered, stable while `inst_req`=1.
- `inst_addr_ok` input 1: bus accepted the address this cycle.
- `inst_rdata` input DATA_W: read data, valid with `inst_data_ok`.
- `inst_data_ok` input 1: read data returned this cycle.
- `inst_o` output DATA_W: instruction to IF/ID.
- `inst_pc_o` output ADDR_W: PC of `inst_o`.
- `inst_valid_o` output 1: one-cycle pulse per handed-off instruction. 0 means bubble.
- `adel_o` output 1: fetch address error, qualified by `inst_valid_o`.

## Operation
States: IDLE, REQ, WAIT, HOLD, DISCARD. The one-bit `flush_pend` flag is set only in REQ.

Handoff is the cycle an instruction is delivered. In that cycle `pc_stall_o`=0 and the output registers load on the edge. In every other cycle `pc_stall_o`=1.

IDLE:
- If `flush_i`: stay in IDLE.
- Else if `pc_i[1:0]`≠0:
  - no bus request is made;
  - if `!id_stall_i`, hand off with `inst_o`=0, `adel_o`=1, `inst_pc_o`=`pc_i`;
  - else stay in IDLE.
- Else: latch `inst_addr`←`pc_i`, set `inst_req`←1, go to REQ.

REQ (`inst_req`=1):
- `inst_req` and `inst_addr` hold until `inst_addr_ok`. A request is never withdrawn.
- `flush_i` without `addr_ok` sets `flush_pend`.
- On `addr_ok`: `inst_req`←0. Go to DISCARD if `flush_i` or `flush_pend`, else go to WAIT. Clear `flush_pend`.

WAIT:
- `flush_i` && `inst_data_ok`: data dropped, go to IDLE.
- `flush_i` only: go to DISCARD.
- `inst_data_ok` && `!id_stall_i`: hand off `inst_rdata`, `inst_pc_o`=`inst_addr`, `adel_o`=0, go to IDLE.
- `inst_data_ok` && `id_stall_i`: capture into the internal buffer, go to HOLD.

HOLD:
- `flush_i`: buffer dropped, go to IDLE.
- Else if `!id_stall_i`: hand off the buffer, go to IDLE.

DISCARD: on `inst_data_ok`, drop the data and go to IDLE. `flush_i` here changes nothing.

Priority: `flush_i` beats `id_stall_i` everywhere. No handoff occurs in a flush cycle, so `pc_stall_o`=1, and the PC clear path wins regardless.

At most one bus transaction is outstanding. `inst_rdata` is never sampled outside WAIT or DISCARD.

## Timing
- Reset values (cycle after `rst`=1):
  - state=IDLE, `flush_pend`=0;
  - `inst_req`=0, `inst_addr`=0;
  - `inst_o`=0, `inst_pc_o`=0, `inst_valid_o`=0, `adel_o`=0;
  - `pc_stall_o`=1 (combinational from state).
- Reset mid-transaction abandons it with no DISCARD. The bus slave shares `rst`.
- Best case, with `addr_ok` on the first REQ cycle and `data_ok` one cycle later:
  - cycle 0: IDLE;
  - cycle 1: REQ, accepted;
  - cycle 2: WAIT, `data_ok` arrives, handoff, `pc_stall_o`=0;
  - cycle 3: `inst_valid_o`=1 and the PC shows the next address.
- Steady-state throughput is 1 instruction per 3 cycles.
- `inst_valid_o` is high for exactly one cycle per handoff. `inst_o`, `inst_pc_o` and `adel_o` hold their values until the next handoff.
- Misaligned PC: handoff happens in the same cycle it is seen in IDLE, and `inst_valid_o`+`adel_o` are high the next cycle.

## Test plan
- Reset, then `pc_i`=0xbfc00000, zero-wait bus returning 0x24080001:
  - `inst_req` high in cycle 1 with `inst_addr`=0xbfc00000;
  - `pc_stall_o`=0 in cycle 2;
  - `inst_valid_o`=1, `inst_o`=0x24080001, `inst_pc_o`=0xbfc00000 in cycle 3.
- `addr_ok` delayed 3 cycles: `inst_req` and `inst_addr` stay constant for 4 cycles, and `pc_stall_o` stays 1 throughout.
- `data_ok` arrives while `id_stall_i`=1 for 2 cycles: go to HOLD with no `inst_valid_o`. Handoff happens the cycle `id_stall_i` drops, with the data intact.
- Flush scenarios:
  - `flush_i` in REQ before `addr_ok`: request stays asserted until `addr_ok`, the returned data is dropped, and no `inst_valid_o` is produced for that PC.
  - `flush_i` coincident with `data_ok` in WAIT: data dropped, next state IDLE.
- `pc_i`=0xbfc00002: `inst_req` stays 0. Next cycle `inst_valid_o`=1, `adel_o`=1, `inst_pc_o`=0xbfc00002, `inst_o`=0.
- `rst` asserted in WAIT: next cycle IDLE with all outputs at their reset values. A late `data_ok` afterwards is ignored.
